max_pool_row_splitter: RTL and testbench

//   Re-segments a compact/dense max-pool feature stream (N items per beat, no holes) back into
//   row-aligned beats: no output beat crosses a feature-map row boundary. Sits on the read-back

---
 rtl/max_pool_row_splitter.sv | 130 +++++++++++++
 tb/tb_max_pool_row_splitter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_row_splitter.sv
// Re-segments a dense N-items-per-beat feature stream into row-aligned beats.
// A 2N-item circular buffer decouples input packing from output row boundaries.
module max_pool_row_splitter #(
    parameter int feature_n_per_clk  = 4,
    parameter int feature_data_width = 8,
    parameter int simulation_delay   = 1
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [15:0]                                      row_width,
    input  logic [feature_n_per_clk*feature_data_width-1:0]  s_axis_data,
    input  logic [feature_n_per_clk*feature_data_width/8-1:0] s_axis_keep,
    input  logic                                             s_axis_last,
    input  logic                                             s_axis_valid,
    output logic                                             s_axis_ready,
    output logic [feature_n_per_clk*feature_data_width-1:0]  m_axis_data,
    output logic [feature_n_per_clk*feature_data_width/8-1:0] m_axis_keep,
    output logic                                             m_axis_user,
    output logic                                             m_axis_last,
    output logic                                             m_axis_valid,
    input  logic                                             m_axis_ready
);

    localparam int N   = feature_n_per_clk;
    localparam int W   = feature_data_width;
    localparam int KPI = W / 8;
    localparam int D   = 2 * N;
    localparam int PW  = $clog2(D);
    localparam int CW  = $clog2(D) + 1;

    if ((W % 8 != 0) || (W <= 0) || (simulation_delay < 0) || (N & (N - 1)) != 0) begin : g_bad_cfg
        $error("max_pool_row_splitter: unsupported parameter set");
    end

    logic [W-1:0]  mem_q [D];
    logic [W-1:0]  mem_d [D];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          eof_pend_q, eof_pend_d;
    // Zero means "reload from row_width on next use".
    logic [15:0]   row_rem_q, row_rem_d;

    logic [N-1:0]  in_mask;
    logic [CW-1:0] in_n, want, out_n;
    logic [15:0]   row_rem_eff, row_width_eff;
    logic          in_fire, out_fire;

    always_comb begin
        in_n = '0;
        for (int i = 0; i < N; i++) begin
            in_mask[i] = s_axis_keep[i*KPI];
            in_n       = in_n + CW'(in_mask[i]);
        end

        row_width_eff = (row_width == 16'd0) ? 16'd1 : row_width;
        row_rem_eff   = (row_rem_q == 16'd0) ? row_width_eff : row_rem_q;
        want          = (row_rem_eff >= 16'(N)) ? CW'(N) : CW'(row_rem_eff);
        out_n         = (eof_pend_q && (cnt_q < want)) ? cnt_q : want;

        s_axis_ready = (cnt_q <= CW'(N)) & ~eof_pend_q;
        m_axis_valid = (cnt_q >= want) | (eof_pend_q & (cnt_q != '0));
        m_axis_last  = m_axis_valid & eof_pend_q & (out_n == cnt_q);
        m_axis_user  = m_axis_valid & ((16'(out_n) == row_rem_eff) | m_axis_last);

        m_axis_data = '0;
        m_axis_keep = '0;
        for (int i = 0; i < N; i++) begin
            if (CW'(i) < out_n) begin
                m_axis_data[i*W +: W]     = mem_q[rptr_q + PW'(i)];
                m_axis_keep[i*KPI +: KPI] = '1;
            end
        end

        in_fire  = s_axis_valid & s_axis_ready;
        out_fire = m_axis_valid & m_axis_ready;
    end

    always_comb begin
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        eof_pend_d = eof_pend_q;
        row_rem_d  = row_rem_q;

        // Keep is low-aligned, so item i lands at wptr+i.
        if (in_fire) begin
            for (int i = 0; i < N; i++) begin
                if (in_mask[i]) mem_d[wptr_q + PW'(i)] = s_axis_data[i*W +: W];
            end
            wptr_d = wptr_q + PW'(in_n);
            cnt_d  = cnt_d + in_n;
            if (s_axis_last) eof_pend_d = 1'b1;
        end

        if (out_fire) begin
            rptr_d    = rptr_q + PW'(out_n);
            cnt_d     = cnt_d - out_n;
            row_rem_d = m_axis_last ? 16'd0 : (row_rem_eff - 16'(out_n));
            if (m_axis_last) eof_pend_d = 1'b0;
        end

        // Map ended on an empty beat with nothing buffered: close it silently.
        if (eof_pend_q && (cnt_q == '0)) begin
            eof_pend_d = 1'b0;
            row_rem_d  = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            eof_pend_q <= 1'b0;
            row_rem_q  <= 16'd0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            eof_pend_q <= eof_pend_d;
            row_rem_q  <= row_rem_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_max_pool_row_splitter.sv
// Randomized bench for max_pool_row_splitter against a row/chunk reference model.
module tb_max_pool_row_splitter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int DW = N * W;
    localparam int KW = N * W / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   row_width;
    logic [DW-1:0] s_axis_data;
    logic [KW-1:0] s_axis_keep;
    logic          s_axis_last, s_axis_valid, s_axis_ready;
    logic [DW-1:0] m_axis_data;
    logic [KW-1:0] m_axis_keep;
    logic          m_axis_user, m_axis_last, m_axis_valid, m_axis_ready;

    max_pool_row_splitter #(
        .feature_n_per_clk (N),
        .feature_data_width(W),
        .simulation_delay  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_width   (row_width),
        .s_axis_data (s_axis_data),
        .s_axis_keep (s_axis_keep),
        .s_axis_last (s_axis_last),
        .s_axis_valid(s_axis_valid),
        .s_axis_ready(s_axis_ready),
        .m_axis_data (m_axis_data),
        .m_axis_keep (m_axis_keep),
        .m_axis_user (m_axis_user),
        .m_axis_last (m_axis_last),
        .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          user;
        logic          last;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] map_items[$];
    int         out_fire_cyc[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         ready_mode = 1;  // 0 low, 1 high, 2 random, 3 toggle
    logic [7:0] item_ctr = 8'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: split the map into rows of max(rw,1), each row into chunks of at most N.
    task automatic model_map(input int rw_in, input bit tail_last);
        int rw;
        int total;
        int idx;
        int pos;
        rw    = (rw_in == 0) ? 1 : rw_in;
        total = map_items.size();
        idx   = 0;
        pos   = 0;
        while (idx < total) begin
            beat_t b;
            int    take;
            take = N;
            if (rw - pos < take) take = rw - pos;
            if (total - idx < take) take = total - idx;
            b.data = '0;
            b.keep = '0;
            for (int j = 0; j < take; j++) begin
                b.data[j*8 +: 8] = map_items[idx+j];
                b.keep[j]        = 1'b1;
            end
            idx   += take;
            pos   += take;
            b.last = (idx == total) && tail_last;
            b.user = (pos == rw) || b.last;
            if (pos == rw) pos = 0;
            exp_q.push_back(b);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        #2;
        case (ready_mode)
            0:       m_axis_ready = 1'b0;
            1:       m_axis_ready = 1'b1;
            2:       m_axis_ready = ($urandom_range(0, 3) != 0);
            default: m_axis_ready = ~m_axis_ready;
        endcase
    end

    // Monitor samples 1 time unit before each rising edge.
    int    outstanding = 0;
    bit    pend = 0;
    bit    stall_pend = 0;
    beat_t stall_b;
    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            outstanding = 0;
            pend        = 0;
            stall_pend  = 0;
        end else begin
            if (outstanding > N) check("ready_when_full", s_axis_ready, 0);
            if (pend) check("ready_when_eof", s_axis_ready, 0);
            if (stall_pend) begin
                check("stall_valid", m_axis_valid, 1);
                check("stall_data", m_axis_data, stall_b.data);
                check("stall_keep", m_axis_keep, stall_b.keep);
                check("stall_user", m_axis_user, stall_b.user);
                check("stall_last", m_axis_last, stall_b.last);
            end
            stall_pend = m_axis_valid && !m_axis_ready;
            stall_b    = '{m_axis_data, m_axis_keep, m_axis_user, m_axis_last};
            if (m_axis_valid && m_axis_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", m_axis_valid, 0);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("out_data", m_axis_data, b.data);
                    check("out_keep", m_axis_keep, b.keep);
                    check("out_user", m_axis_user, b.user);
                    check("out_last", m_axis_last, b.last);
                end
                out_fire_cyc.push_back(cyc);
                outstanding -= $countones(m_axis_keep);
                if (m_axis_last) pend = 0;
            end
            if (s_axis_valid && s_axis_ready) begin
                outstanding += $countones(s_axis_keep);
                if (s_axis_last && s_axis_keep != '0) pend = 1;
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input int n, input bit last,
                             output int waited);
        waited = 0;
        @(negedge clk);
        s_axis_data  = d;
        s_axis_keep  = KW'((1 << n) - 1);
        s_axis_last  = last;
        s_axis_valid = 1'b1;
        #1;
        while (!s_axis_ready && waited < 500) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 500) check("in_timeout", waited, 0);
        else @(posedge clk);
        #1;
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic fill_items(input int nitems);
        map_items.delete();
        for (int i = 0; i < nitems; i++) begin
            map_items.push_back(item_ctr);
            item_ctr++;
        end
    endtask

    task automatic send_items(input int nitems, input bit gaps, input bit tput, input bit last);
        int idx;
        int n;
        int w;
        logic [DW-1:0] d;
        idx = 0;
        while (idx < nitems) begin
            n = (nitems - idx < N) ? nitems - idx : N;
            d = DW'($urandom);
            for (int j = 0; j < n; j++) d[j*8 +: 8] = map_items[idx+j];
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(d, n, last && (idx + n == nitems), w);
            if (tput) check("tput_ready_wait", w, 0);
            idx += n;
        end
    endtask

    task automatic run_map(input int rw, input int nitems, input bit gaps, input bit tput);
        row_width = 16'(rw);
        fill_items(nitems);
        model_map(rw, 1'b1);
        send_items(nitems, gaps, tput, 1'b1);
        wait_drain();
    endtask

    initial begin
        int w;
        rst_n        = 1'b0;
        row_width    = 16'd4;
        s_axis_data  = '0;
        s_axis_keep  = '0;
        s_axis_last  = 1'b0;
        s_axis_valid = 1'b0;
        m_axis_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_m_valid", m_axis_valid, 0);
        check("rst_m_last", m_axis_last, 0);
        check("rst_m_user", m_axis_user, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_s_ready", s_axis_ready, 1);
        check("rst_m_valid_rel", m_axis_valid, 0);

        // Rows of 6 over three full beats.
        ready_mode = 1;
        run_map(6, 12, 0, 0);

        // Row width equal to N: full throughput.
        out_fire_cyc.delete();
        run_map(4, 16, 0, 1);
        check("tput_beats", out_fire_cyc.size(), 4);
        if (out_fire_cyc.size() == 4)
            check("tput_span", out_fire_cyc[3] - out_fire_cyc[0], 3);

        // Map ends mid-row, then the next map restarts the row.
        run_map(10, 8, 0, 0);
        run_map(10, 12, 0, 0);

        // Backpressure toggling with short rows.
        ready_mode = 3;
        run_map(3, 14, 0, 0);
        run_map(0, 6, 0, 0);

        // Empty last beat after everything has drained.
        ready_mode = 1;
        row_width  = 16'd4;
        fill_items(4);
        model_map(4, 1'b0);
        send_items(4, 0, 0, 1'b0);
        wait_drain();
        send_beat(DW'($urandom), 0, 1'b1, w);
        repeat (2) @(posedge clk);
        #1;
        check("eof_empty_ready", s_axis_ready, 1);
        check("eof_empty_valid", m_axis_valid, 0);
        run_map(3, 5, 0, 0);

        // Reset with 5 items buffered.
        ready_mode = 0;
        @(posedge clk);
        #3;
        row_width = 16'd8;
        fill_items(5);
        send_items(5, 0, 0, 1'b0);
        @(negedge clk);
        #1;
        check("pre_rst_valid", m_axis_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", m_axis_valid, 0);
        check("midrst_last", m_axis_last, 0);
        check("midrst_user", m_axis_user, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_ready", s_axis_ready, 1);
        check("postrst_valid", m_axis_valid, 0);
        ready_mode = 2;
        run_map(5, 7, 1, 0);

        for (int m = 0; m < 25; m++) begin
            ready_mode = $urandom_range(1, 3);
            run_map($urandom_range(0, 9), $urandom_range(1, 20), 1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
